// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
//
// Press-pattern decoder placed after the input glitch filter. It takes the
// filtered level and its one-cycle rise/fall pulses and classifies every
// button interaction as a short press, a long press or a double click. Each
// interaction produces single-cycle event pulses, and two status levels are
// provided for firmware and LED logic. All timing runs on a prescaled tick, so
// millisecond-range human timings work at any system clock frequency.
//
// Parameters
//   TICK_DIV   : clock cycles per tick (>= 1)
//   LONG_TICKS : ticks a press must last to count as long (>= 1, < 2^TW)
//   DBL_TICKS  : max ticks from first release to second press (>= 1, < 2^TW)
//   TW         : tick counter width
//   ACTIVE_LOW : 1 -> press = btn_fall, release = btn_rise; 0 -> swapped
//
// Ports
//   clk        in  : system clock
//   rst_n      in  : asynchronous active-low reset
//   btn_val    in  : filtered button level (not needed for decoding)
//   btn_rise   in  : one-cycle rising-edge pulse from the filter
//   btn_fall   in  : one-cycle falling-edge pulse from the filter
//   evt_short  out : one-cycle pulse, short press
//   evt_long   out : one-cycle pulse, long-press threshold reached
//   evt_double out : one-cycle pulse, double click
//   held       out : high while a long press is still held
//   busy       out : high whenever the decoder is not idle
// -----------------------------------------------------------------------------
module button_events #(
    parameter int TICK_DIV   = 1000,
    parameter int LONG_TICKS = 500,
    parameter int DBL_TICKS  = 250,
    parameter int TW         = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_val,
    input  logic btn_rise,
    input  logic btn_fall,
    output logic evt_short,
    output logic evt_long,
    output logic evt_double,
    output logic held,
    output logic busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    // Expiry is detected one cycle before tc would reach the threshold so the
    // registered event lands exactly T*TICK_DIV cycles after state entry.
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0] DBL_LAST  = TW'(DBL_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   pre_q;
    logic [TW-1:0]   tc_q;

    logic            both_edges;
    logic            press;
    logic            rel_e;
    logic            tick;
    logic            long_due;
    logic            dbl_due;
    logic            counting;
    logic            short_d;
    logic            long_d;
    logic            dbl_d;

    // The level input is only of interest to status consumers elsewhere.
    logic            unused_btn_val;
    assign unused_btn_val = btn_val;

    // Edge decode: a cycle carrying both pulses is ambiguous and is dropped.
    assign both_edges = btn_rise & btn_fall;
    assign press      = ((ACTIVE_LOW != 0) ? btn_fall : btn_rise) & ~both_edges;
    assign rel_e      = ((ACTIVE_LOW != 0) ? btn_rise : btn_fall) & ~both_edges;

    assign tick     = (pre_q == PRE_LAST);
    assign long_due = tick && (tc_q == LONG_LAST);
    assign dbl_due  = tick && (tc_q == DBL_LAST);

    // Only the three timed states run the tick counter; IDLE and LONG keep it
    // cleared, which also guarantees tc can never wrap.
    assign counting = (state_q == S_PRESS1) || (state_q == S_WAIT2) ||
                      (state_q == S_PRESS2);

    // Next-state and event decode. Edges are checked before expiry in every
    // state so a coincident edge always wins the race.
    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A release here belongs to a press that started before reset.
                if (press) begin
                    state_d = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (rel_e) begin
                    state_d = S_WAIT2;
                end else if (long_due) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                end
            end
            S_WAIT2: begin
                if (press) begin
                    state_d = S_PRESS2;
                end else if (dbl_due) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                end
            end
            S_PRESS2: begin
                if (rel_e) begin
                    state_d = S_IDLE;
                    dbl_d   = 1'b1;
                end else if (long_due) begin
                    // First click was a short press; this one is long.
                    state_d = S_LONG;
                    short_d = 1'b1;
                    long_d  = 1'b1;
                end
            end
            S_LONG: begin
                if (rel_e) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            evt_short  <= 1'b0;
            evt_long   <= 1'b0;
            evt_double <= 1'b0;
            held       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            evt_short  <= short_d;
            evt_long   <= long_d;
            evt_double <= dbl_d;
            held       <= (state_d == S_LONG);
            busy       <= (state_d != S_IDLE);
        end
    end

    // Prescaler and tick counter; any state change restarts both so tc always
    // counts whole ticks since the current state was entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            tc_q  <= '0;
        end else if ((state_d != state_q) || !counting) begin
            pre_q <= '0;
            tc_q  <= '0;
        end else if (tick) begin
            pre_q <= '0;
            tc_q  <= tc_q + TW'(1);
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

endmodule

// File: tb/tb_button_events.sv
// -----------------------------------------------------------------------------
// tb_button_events
//
// Directed bench for button_events with TICK_DIV=4, LONG_TICKS=10,
// DBL_TICKS=5, ACTIVE_LOW=1. Each table record gives a number of quiet cycles,
// then one cycle of rise/fall input, and the outputs
// {evt_short, evt_long, evt_double, held, busy} expected in the following
// cycle. Quiet cycles are themselves checked: no events, held/busy unchanged.
// Reset behaviour is exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_button_events;

    logic clk;
    logic rst_n;
    logic btn_val;
    logic btn_rise;
    logic btn_fall;
    logic evt_short;
    logic evt_long;
    logic evt_double;
    logic held;
    logic busy;

    int n_cmp;
    int n_bad;

    typedef struct {
        int         gap;
        logic       rise;
        logic       fall;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    button_events #(
        .TICK_DIV  (4),
        .LONG_TICKS(10),
        .DBL_TICKS (5),
        .TW        (16),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_val   (btn_val),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .evt_short (evt_short),
        .evt_long  (evt_long),
        .evt_double(evt_double),
        .held      (held),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {evt_short, evt_long, evt_double, held, busy};
    endfunction

    task automatic check(input string name, input int idx, input logic [4:0] got,
                         input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got sh/lg/db/held/busy=%b, want %b",
                     name, idx, $time, got, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle of input, advance to the next
    // falling edge and compare the outputs registered from that input.
    task automatic cyc(input logic r, input logic f, input logic [4:0] exp,
                       input string name, input int idx);
        btn_rise = r;
        btn_fall = f;
        if (f && !r) btn_val = 1'b0;
        if (r && !f) btn_val = 1'b1;
        @(negedge clk);
        btn_rise = 1'b0;
        btn_fall = 1'b0;
        check(name, idx, outs(), exp);
    endtask

    function automatic void add(input int gap, input logic r, input logic f,
                                input logic [4:0] exp);
        vec_t v;
        v.gap  = gap;
        v.rise = r;
        v.fall = f;
        v.exp  = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [1:0] hb;
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        btn_val  = 1'b1;
        btn_rise = 1'b0;
        btn_fall = 1'b0;

        // Stimulus table; cycle numbers are relative to each scenario's first edge.
        // Short press: fall 0, rise 20, evt_short at 41.
        add(3,  1'b0, 1'b1, 5'b00001);
        add(19, 1'b1, 1'b0, 5'b00001);
        add(19, 1'b0, 1'b0, 5'b10000);
        // Long press: fall 0, evt_long + held at 41, rise 100, held drops at 101.
        add(3,  1'b0, 1'b1, 5'b00001);
        add(39, 1'b0, 1'b0, 5'b01011);
        add(59, 1'b1, 1'b0, 5'b00000);
        // Double click: fall 0, rise 8, fall 15, rise 22, evt_double at 23.
        add(3,  1'b0, 1'b1, 5'b00001);
        add(7,  1'b1, 1'b0, 5'b00001);
        add(6,  1'b0, 1'b1, 5'b00001);
        add(6,  1'b1, 1'b0, 5'b00100);
        add(30, 1'b0, 1'b0, 5'b00000);
        // Release coincides with the long expiry (cycle 40): short path.
        add(3,  1'b0, 1'b1, 5'b00001);
        add(39, 1'b1, 1'b0, 5'b00001);
        add(19, 1'b0, 1'b0, 5'b10000);
        // Second press coincides with the double-click deadline (cycle 24).
        add(3,  1'b0, 1'b1, 5'b00001);
        add(3,  1'b1, 1'b0, 5'b00001);
        add(19, 1'b0, 1'b1, 5'b00001);
        add(5,  1'b1, 1'b0, 5'b00100);
        // Second press held: short+long together at 47, then held.
        add(3,  1'b0, 1'b1, 5'b00001);
        add(2,  1'b1, 1'b0, 5'b00001);
        add(2,  1'b0, 1'b1, 5'b00001);
        add(39, 1'b0, 1'b0, 5'b11011);
        add(5,  1'b1, 1'b0, 5'b00000);
        // Simultaneous rise+fall is ignored, in IDLE and in PRESS1.
        add(3,  1'b1, 1'b1, 5'b00000);
        add(2,  1'b0, 1'b1, 5'b00001);
        add(2,  1'b1, 1'b1, 5'b00001);
        add(2,  1'b1, 1'b0, 5'b00001);
        add(19, 1'b0, 1'b0, 5'b10000);
        add(5,  1'b0, 1'b0, 5'b00000);

        // Reset state, including an edge presented while reset is held.
        @(negedge clk);
        check("rst_hold", 0, outs(), 5'b00000);
        cyc(1'b0, 1'b1, 5'b00000, "rst_edge", 0);
        btn_val = 1'b1;
        rst_n   = 1'b1;
        cyc(1'b0, 1'b0, 5'b00000, "rst_rel", 0);

        hb = 2'b00;
        foreach (vecs[i]) begin
            for (int g = 0; g < vecs[i].gap; g++) begin
                cyc(1'b0, 1'b0, {3'b000, hb}, "quiet", i);
            end
            cyc(vecs[i].rise, vecs[i].fall, vecs[i].exp, "vec", i);
            hb = vecs[i].exp[1:0];
        end

        // Reset in the middle of PRESS1 clears outputs without a clock edge.
        cyc(1'b0, 1'b1, 5'b00001, "mid_press", 0);
        for (int g = 0; g < 3; g++) cyc(1'b0, 1'b0, 5'b00001, "mid_hold", g);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 0, outs(), 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        // Stray release from the pre-reset press: stays idle, no event ever.
        cyc(1'b1, 1'b0, 5'b00000, "stray_rise", 0);
        for (int g = 0; g < 50; g++) cyc(1'b0, 1'b0, 5'b00000, "post_rst", g);
        // Decoder still works after the interrupted interaction.
        cyc(1'b0, 1'b1, 5'b00001, "post_press", 0);
        for (int g = 0; g < 5; g++) cyc(1'b0, 1'b0, 5'b00001, "post_p1", g);
        cyc(1'b1, 1'b0, 5'b00001, "post_rel", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
